// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================
// mdu_pkg : opcode/state types shared by the iterative MDU
// Rev 1.0
// ============================================================
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } mdu_state_t;

  function automatic logic op_is_muldiv(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_step.sv
`default_nettype none
// ============================================================
// mdu_step : one shift-add (multiply) or restoring trial-subtract
//            (divide) iteration. Rev 1.0
// ============================================================
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             div,
  input  logic [WIDTH:0]   upper,
  input  logic [WIDTH-1:0] lower,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH:0]   upper_nx,
  output logic [WIDTH-1:0] lower_nx
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    // upper holds the partial product (top bit clear) or the partial remainder
    sum     = upper + {1'b0, opnd & {WIDTH{lower[0]}}};
    shifted = {upper[WIDTH-1:0], lower[WIDTH-1]};
    diff    = shifted - {1'b0, opnd};
    if (div) begin
      if (diff[WIDTH]) begin
        upper_nx = shifted;
        lower_nx = {lower[WIDTH-2:0], 1'b0};
      end else begin
        upper_nx = diff;
        lower_nx = {lower[WIDTH-2:0], 1'b1};
      end
    end else begin
      upper_nx = {1'b0, sum[WIDTH:1]};
      lower_nx = {sum[0], lower[WIDTH-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================
// mdu_iter : iterative MULT/MULTU/DIV/DIVU unit with HI/LO and
//            single-cycle MTHI/MTLO. Rev 1.0
// ============================================================
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  mdu_state_t state, state_nx;

  logic [CW-1:0]      iter;
  logic               op_div, op_signed, sign_a, sign_b, div_zero;
  logic [WIDTH:0]     upper, upper_nx;
  logic [WIDTH-1:0]   lower, lower_nx, opnd;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               load, step_en, commit, write_hi, write_lo;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   quotient, remainder;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && op_is_muldiv(op)) state_nx = RUN;
      RUN:     if (iter == LAST_ITER) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load     = (state == IDLE) && start && op_is_muldiv(op);
    write_hi = (state == IDLE) && start && (op == OP_MTHI);
    write_lo = (state == IDLE) && start && (op == OP_MTLO);
    step_en  = (state == RUN);
    commit   = (state == FINISH);
  end

  assign busy = (state != IDLE);

  always_comb begin
    mag_a = (op_is_signed(op) && a[WIDTH-1]) ? -a : a;
    mag_b = (op_is_signed(op) && b[WIDTH-1]) ? -b : b;
  end

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .div      (op_div),
    .upper    (upper),
    .lower    (lower),
    .opnd     (opnd),
    .upper_nx (upper_nx),
    .lower_nx (lower_nx)
  );

  // Divide-by-zero leaves |a| as remainder; the dividend-sign fix restores a itself.
  always_comb begin
    product = {upper[WIDTH-1:0], lower};
    if (op_signed && (sign_a ^ sign_b)) product = -product;
    quotient = lower;
    if (op_signed && (sign_a ^ sign_b) && !div_zero) quotient = -quotient;
    remainder = upper[WIDTH-1:0];
    if (op_signed && sign_a) remainder = -remainder;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iter      <= '0;
      op_div    <= 1'b0;
      op_signed <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      div_zero  <= 1'b0;
      upper     <= '0;
      lower     <= '0;
      opnd      <= '0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      done <= commit;
      if (load) begin
        op_div    <= op_is_div(op);
        op_signed <= op_is_signed(op);
        sign_a    <= op_is_signed(op) & a[WIDTH-1];
        sign_b    <= op_is_signed(op) & b[WIDTH-1];
        div_zero  <= (b == '0);
        opnd      <= op_is_div(op) ? mag_b : mag_a;
        lower     <= op_is_div(op) ? mag_a : mag_b;
        upper     <= '0;
        iter      <= '0;
      end
      if (step_en) begin
        upper <= upper_nx;
        lower <= lower_nx;
        iter  <= iter + CW'(1);
      end
      if (write_hi) hi <= a;
      if (write_lo) lo <= a;
      if (commit) begin
        if (op_div) begin
          hi <= remainder;
          lo <= quotient;
        end else begin
          hi <= product[2*WIDTH-1:WIDTH];
          lo <= product[WIDTH-1:0];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core, parametrised in operand width. It executes MULT, MULTU, DIV and DIVU over multiple cycles using a one-bit-per-cycle shift-add or restoring-divide datapath, and handles MTHI/MTLO in a single cycle. It sits beside the single-cycle ALU. The controller stalls the PC while `busy` is high and reads `hi`/`lo` for MFHI/MFLO.

## Interface
- `WIDTH`, default 32: operand, HI and LO width. Must be at least 2.
- `clk`  in  1: clock. All state changes on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `start`  in  1: request. Sampled only when `busy`=0.
- `op`  in  3: `mdu_op_t` (0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 reserved).
- `a`  in  WIDTH: rs value (multiplicand, dividend, or MTHI/MTLO data).
- `b`  in  WIDTH: rt value (multiplier or divisor).
- `busy`  out  1: operation in progress. Reset value 0.
- `done`  out  1: one-cycle pulse when HI/LO are committed. Reset value 0.
- `hi`  out  WIDTH: HI register. Reset value 0.
- `lo`  out  WIDTH: LO register. Reset value 0.

## Operation
- FSM states, in `mdu_state_t`: IDLE, RUN, FINISH. `busy` = (state != IDLE).
- IDLE, with `start`=1 and a mul/div op:
  - capture `op`;
  - for signed ops, capture |a| and |b| as WIDTH-bit unsigned values, plus sign(a) and sign(b);
  - for unsigned ops, capture a and b raw;
  - clear the iteration counter and go to RUN.
- IDLE, with `start`=1 and MTHI or MTLO: write `a` into `hi` or `lo`. Stay in IDLE, no `done`.
- IDLE, with `start`=1 and a reserved op: ignored.
- RUN: perform one iteration per cycle for exactly WIDTH cycles, then go to FINISH.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring step. The remainder register is WIDTH+1 bits so the trial subtract carries no overflow.
- FINISH: apply the sign correction, write HI/LO, pulse `done`, return to IDLE.
  - MULT: negate the 2·WIDTH product when the signs differ.
  - DIV: negate the quotient when the signs differ. The remainder takes the sign of the dividend.
  - Multiply: HI = product[2W-1:W], LO = product[W-1:0].
  - Divide: LO = quotient, HI = remainder.
- Divide by zero (b=0, signed or unsigned): LO = all ones, HI = a. No sign correction is applied.
- Signed overflow (a=MIN, b=−1): LO = MIN, HI = 0. This falls out of the magnitude datapath; no special case is needed.
- `start` while `busy`=1 is ignored for all ops, including MTHI/MTLO.
- `hi` and `lo` hold their old values throughout RUN and FINISH.
- All arithmetic is modulo 2^WIDTH (or 2^(2·WIDTH) for the product). Negation is two's complement.

## Timing
- Start accepted at edge E:
  - `busy`=1 in the WIDTH+1 cycles following edges E through E+WIDTH.
  - HI/LO are written at edge E+WIDTH+1.
  - `done`=1 and `busy`=0 in the single cycle after edge E+WIDTH+1.
- Latency is WIDTH+1 cycles from the start edge to the commit edge. For WIDTH=32, that is 33.
- MTHI/MTLO: the new value is visible in the cycle after the start edge.
- A `start` in the cycle where `done`=1 is accepted, because state is IDLE. This allows back-to-back operation with no bubble.
- `reset`=1 at any edge, including mid-RUN or FINISH:
  - state goes to IDLE;
  - `hi`=`lo`=0, `busy`=0, `done`=0;
  - any in-flight operation is discarded;
  - reset takes priority over `start`.
- No combinational path from inputs to outputs. All outputs are registered.

## Structure
- Package `mdu_pkg` holds `mdu_op_t` (3-bit enum with the values above) and `mdu_state_t`.
- The iteration counter is $clog2(WIDTH+1) bits.
- Single module. The per-cycle step (one shift-add or one trial-subtract) is a natural sub-module, `mdu_step`, parametrised by WIDTH.

## Test plan
All cases use WIDTH=32 unless noted.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. `done` exactly 33 cycles after the start edge; `busy` high for 33 cycles.
- MULT a=0xFFFFFFFD (−3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1.
- DIV a=0x12345678, b=0 → lo=0xFFFFFFFF, hi=0x12345678. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0xA5A5A5A5 in IDLE → hi=0xA5A5A5A5 next cycle, no `done`.
  - MTLO issued mid-MULT → ignored; lo keeps the MULT result.
  - Reset asserted at iteration 10 → busy=0, hi=lo=0 next cycle, no `done` pulse.
- Back-to-back: DIVU started in the `done` cycle of a MULTU → both results correct, second `done` 33 cycles later. Repeat MULT/DIV checks at WIDTH=8 against a reference model with random operands.
